// File: rtl/staged_logic_pipe.sv
// Bitwise combine/reduce pipeline of DEPTH valid/ready register stages with
// bubble collapsing, synchronous flush and a registered occupancy count.
module staged_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [WIDTH-1:0]           c,
    input  logic [WIDTH-1:0]           d,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           z,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int MID   = DEPTH - 1;

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] en;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] p_q [MID];
    logic [WIDTH-1:0] p_d [MID];
    logic [WIDTH-1:0] q_q [MID];
    logic [WIDTH-1:0] q_d [MID];
    logic [WIDTH-1:0] z_q, z_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [WIDTH-1:0] reduce_op(input logic [WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0] q);
        case (MODE)
            1:       return p & q;
            2:       return p | q;
            default: return p ^ q;
        endcase
    endfunction

    // A stage may advance when it is empty or the stage ahead of it advances.
    always_comb begin
        logic carry;
        carry        = !v_q[DEPTH-1] || out_ready;
        en[DEPTH-1]  = carry;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            carry = !v_q[k] || carry;
            en[k] = carry;
        end
    end

    assign src_v = {v_q[DEPTH-2:0], in_valid};

    always_comb begin
        v_d = v_q;
        p_d = p_q;
        q_d = q_q;
        z_d = z_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (en[k]) v_d[k] = src_v[k];
        end
        if (!flush) begin
            if (en[0] && in_valid) begin
                p_d[0] = a & b;
                q_d[0] = c | d;
            end
            for (int k = 1; k < MID; k++) begin
                if (en[k] && v_q[k-1]) begin
                    p_d[k] = p_q[k-1];
                    q_d[k] = q_q[k-1];
                end
            end
            if (en[DEPTH-1] && v_q[DEPTH-2]) z_d = reduce_op(p_q[MID-1], q_q[MID-1]);
        end
        if (flush) v_d = '0;
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) occ_d = occ_d + OCC_W'(v_d[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared too, so z reads 0 after reset rather than stale data.
            v_q   <= '0;
            z_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < MID; k++) begin
                p_q[k] <= '0;
                q_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            p_q   <= p_d;
            q_q   <= q_d;
            z_q   <= z_d;
            occ_q <= occ_d;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[DEPTH-1];
    assign z         = z_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_staged_logic_pipe.sv
// Self-checking bench: four MODE variants driven in parallel, checked every cycle
// against a position-queue model, plus literal checks for the directed scenarios.
module tb_staged_logic_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a, b, c, d;
    logic             in_valid, out_ready, flush;

    logic [WIDTH-1:0] zm  [4];
    logic             ovm [4];
    logic             irm [4];
    logic [1:0]       occm[4];

    staged_logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
        .in_ready(irm[0]), .z(zm[0]), .out_valid(ovm[0]), .out_ready(out_ready),
        .flush(flush), .occupancy(occm[0]));
    staged_logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
        .in_ready(irm[1]), .z(zm[1]), .out_valid(ovm[1]), .out_ready(out_ready),
        .flush(flush), .occupancy(occm[1]));
    staged_logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
        .in_ready(irm[2]), .z(zm[2]), .out_valid(ovm[2]), .out_ready(out_ready),
        .flush(flush), .occupancy(occm[2]));
    staged_logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(3)) dut3 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
        .in_ready(irm[3]), .z(zm[3]), .out_valid(ovm[3]), .out_ready(out_ready),
        .flush(flush), .occupancy(occm[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_z(input int mode, input logic [WIDTH-1:0] p,
                                                input logic [WIDTH-1:0] q);
        if (mode == 1) return p & q;
        if (mode == 2) return p | q;
        return p ^ q;
    endfunction

    // Model: in-flight entries oldest first, each with the stage index it occupies.
    typedef struct {
        int               pos;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
    } ent_t;

    ent_t mq[$];
    bit   model_live = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        bit   out_hs, acc;
        int   lim;
        model_live = 1'b1;
        if (rst) begin
            mq.delete();
        end else begin
            out_hs = (mq.size() > 0) && (mq[0].pos == DEPTH - 1) && out_ready;
            acc    = in_valid && ((mq.size() < DEPTH) || out_ready);
            if (out_hs) void'(mq.pop_front());
            for (int i = 0; i < mq.size(); i++) begin
                lim = (i == 0) ? DEPTH - 1 : mq[i-1].pos - 1;
                e   = mq[i];
                if (e.pos < lim) e.pos = e.pos + 1;
                mq[i] = e;
            end
            if (flush) begin
                mq.delete();
            end else if (acc) begin
                e.pos = 0;
                e.p   = a & b;
                e.q   = c | d;
                mq.push_back(e);
            end
        end
    end

    int dut_delivered = 0;

    always @(negedge clk) begin
        bit exp_ov;
        if (model_live) begin
            exp_ov = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
            check("occupancy", 32'(occm[0]), 32'(mq.size()));
            check("out_valid", 32'(ovm[0]), 32'(exp_ov));
            check("in_ready", 32'(irm[0]), 32'((mq.size() < DEPTH) || out_ready));
            if (exp_ov) begin
                for (int m = 0; m < 4; m++) begin
                    check($sformatf("z_mode%0d", m), 32'(zm[m]), 32'(exp_z(m, mq[0].p, mq[0].q)));
                    check($sformatf("out_valid_mode%0d", m), 32'(ovm[m]), 32'd1);
                end
            end
            if (ovm[0] === 1'b1 && out_ready) dut_delivered++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = WIDTH'($urandom);
        d = WIDTH'($urandom);
    endtask

    initial begin
        int base;
        logic [WIDTH-1:0] held_z;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        a = '0; b = '0; c = '0; d = '0;

        // Reset
        tick();
        tick();
        check("reset_z", 32'(zm[0]), 32'h0);
        check("reset_out_valid", 32'(ovm[0]), 32'h0);
        check("reset_occupancy", 32'(occm[0]), 32'h0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 32'(irm[0]), 32'h1);

        // Single op, latency DEPTH, all modes
        out_ready = 1'b1;
        a = 8'hF0; b = 8'hCC; c = 8'h0A; d = 8'h05; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_cycle1_valid", 32'(ovm[0]), 32'h0);
        tick();
        check("single_cycle2_valid", 32'(ovm[0]), 32'h0);
        tick();
        check("single_cycle3_valid", 32'(ovm[0]), 32'h1);
        check("single_z_xor", 32'(zm[0]), 32'hCF);
        check("single_z_and", 32'(zm[1]), 32'h00);
        check("single_z_or", 32'(zm[2]), 32'hCF);
        check("single_z_mode3", 32'(zm[3]), 32'hCF);
        tick();
        check("single_cycle4_valid", 32'(ovm[0]), 32'h0);

        // Back-to-back
        base = dut_delivered;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            in_valid = 1'b1;
            #1;
            check("b2b_in_ready", 32'(irm[0]), 32'h1);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("b2b_count", 32'(dut_delivered - base), 32'd10);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            tick();
        end
        #1;
        check("bp_occupancy", 32'(occm[0]), 32'd3);
        check("bp_in_ready", 32'(irm[0]), 32'h0);
        held_z = zm[0];
        tick();
        check("bp_z_held", 32'(zm[0]), 32'(held_z));
        check("bp_valid_held", 32'(ovm[0]), 32'h1);
        in_valid  = 1'b0;
        base      = dut_delivered;
        out_ready = 1'b1;
        repeat (5) tick();
        check("bp_drain_count", 32'(dut_delivered - base), 32'd3);

        // Bubble collapse
        out_ready = 1'b0;
        rand_ops(); in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        rand_ops(); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bubble_occupancy", 32'(occm[0]), 32'd2);
        check("bubble_valid", 32'(ovm[0]), 32'h1);
        base      = dut_delivered;
        out_ready = 1'b1;
        tick();
        check("bubble_second_valid", 32'(ovm[0]), 32'h1);
        tick();
        check("bubble_empty", 32'(ovm[0]), 32'h0);
        check("bubble_count", 32'(dut_delivered - base), 32'd2);

        // Flush mid-flight, with a same-cycle input that must be dropped
        rand_ops(); in_valid = 1'b1; tick();
        rand_ops(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(ovm[0]), 32'h0);
        check("flush_occupancy", 32'(occm[0]), 32'h0);
        base = dut_delivered;
        repeat (4) tick();
        check("flush_no_stale", 32'(dut_delivered - base), 32'h0);

        // Reset mid-flight
        rand_ops(); in_valid = 1'b1; tick();
        rand_ops(); tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(ovm[0]), 32'h0);
        check("rst_occupancy", 32'(occm[0]), 32'h0);
        base = dut_delivered;
        repeat (4) tick();
        check("rst_no_stale", 32'(dut_delivered - base), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rand_ops();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        check("final_empty", 32'(occm[0]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
